parking_controller_n: RTL and testbench
=======================================

// Module: parking_controller_n
// PURPOSE
//  Parametrised N-slot parking lot controller; successor of the fixed 4-slot Circuit.
//  Turns entry/exit sensor pulses into slot allocation and release, and reports free capacity and the best free slot.
//  Drives door, full and reject lights. Sits between sensor front-end and the seven-segment display driver.
//  Adds over 4-slot version: N slots, edge-detected sensors, timed door, reject flag, maintenance lock.
// PARAMETERS
//  SLOTS      8                     number of parking slots (>=2)
//  IDX_W      $clog2(SLOTS)         slot index width
//  CNT_W      $clog2(SLOTS+1)       free-count width
//  DOOR_HOLD  4                     cycles door_open_light stays high after an accepted event (>=1)
// PORTS
//  clk              in   1      single clock, all logic on rising edge
//  rst              in   1      synchronous, active-high reset
//  entry_sensor     in   1      car at entry gate (level; rising edge = request)
//  exit_sensor      in   1      car at exit gate (level; rising edge = request)
//  exit_slot        in   IDX_W  slot being vacated, sampled with exit edge
//  lock_en          in   1      maintenance lock: entries rejected, exits allowed
//  parking_slots    out  SLOTS  bit i = 1 -> slot i occupied
//  capacity         out  CNT_W  number of free slots
//  best_place       out  IDX_W  lowest-index free slot; 0 when full
//  full_light       out  1      1 when capacity == 0
//  door_open_light  out  1      door open
//  reject_light     out  1      one-cycle pulse on any rejected request
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): parking_slots=0, capacity=SLOTS, best_place=0, full_light=0,
//   door_open_light=0, reject_light=0, door timer=0. Sensor history regs load current sensor levels,
//   so a sensor held high through reset produces no event. Reset mid-operation aborts door timing.
//  Edge detect: event when sensor=1 at edge k and was 0 at edge k-1. Level held high = one event.
//  Latency: all outputs registered. Slot, capacity, best_place, full and door update at edge k itself.
//  Entry accept: not full and lock_en=0 -> set bit best_place (value before edge k).
//   Otherwise reject: slots unchanged, reject_light=1 for one cycle.
//  Exit accept: parking_slots[exit_slot]=1 and exit_slot<SLOTS -> clear that bit.
//   Otherwise reject as above.
//  Simultaneous entry+exit events at same edge: both evaluated against pre-edge state.
//   Entry allocated from pre-edge free set, so entry when full is rejected even if exit frees a slot.
//   Any reject in the pair sets reject_light; the other event still applies.
//  capacity = SLOTS - popcount(parking_slots); best_place/full_light recomputed from new slot vector,
//   registered consistently (never a cycle stale relative to parking_slots).
//  Door FSM: CLOSED -> OPEN on any accepted event, timer=DOOR_HOLD.
//   OPEN: timer decrements each cycle; door_open_light=1 while timer!=0; OPEN -> CLOSED when timer reaches 0.
//   New accepted event while OPEN reloads timer to DOOR_HOLD. Rejected events never open door.
//  capacity never underflows or exceeds SLOTS; no wrap-around permitted.
// TESTING (SLOTS=4, DOOR_HOLD=3 unless noted)
//  1 Reset, rst=1 two cycles -> slots=0000, capacity=4, best_place=0, full=0, door=0, reject=0.
//  2 Five entry pulses spaced 5 cycles -> slots 0001,0011,0111,1111, capacity 3,2,1,0, full=1 after 4th;
//    5th -> reject pulse 1 cycle, slots stay 1111, door stays 0.
//  3 From 1111 exit exit_slot=1 -> 1101, capacity=1, best_place=1, full=0; repeat exit slot 1 -> reject, 1101.
//  4 From 0111 entry+exit same edge with exit_slot=0 -> 1110, capacity=1, best_place=0, no reject;
//    from 1111 entry+exit(slot 2) -> 1011, reject=1.
//  5 Door: accepted entry -> door high exactly 3 cycles; second accept 2 cycles later -> high until 3 cycles after it;
//    entry_sensor held high 10 cycles -> exactly one allocation.
//  6 lock_en=1 entry -> reject, slots unchanged; exit still accepted. Mid door-open rst=1 with entry_sensor
//    high -> reset values next cycle, no allocation after rst release. Repeat 2-3 with SLOTS=8.

Source files
------------

// File: rtl/parking_controller_n.sv
// -----------------------------------------------------------------------------
// parking_controller_n
//
// Purpose:
//   N-slot parking lot controller. It turns entry and exit sensor pulses into
//   slot allocation and release. It reports the free capacity and the
//   lowest-index free slot. It drives the door, full and reject lights.
//   All outputs are registered and reflect the effect of an event at the same
//   clock edge that detects the event.
//
// Parameters:
//   SLOTS      number of parking slots (>= 2)
//   IDX_W      slot index width
//   CNT_W      free-count width
//   DOOR_HOLD  cycles the door light stays high after an accepted event (>= 1)
//
// Ports:
//   clk              in   1      rising-edge clock
//   rst              in   1      synchronous active-high reset
//   entry_sensor     in   1      car at entry gate (level; rising edge = request)
//   exit_sensor      in   1      car at exit gate (level; rising edge = request)
//   exit_slot        in   IDX_W  slot being vacated, sampled with the exit edge
//   lock_en          in   1      maintenance lock: entries rejected, exits allowed
//   parking_slots    out  SLOTS  bit i set -> slot i occupied
//   capacity         out  CNT_W  number of free slots
//   best_place       out  IDX_W  lowest-index free slot, 0 when full
//   full_light       out  1      high when capacity is 0
//   door_open_light  out  1      door open
//   reject_light     out  1      one-cycle pulse on any rejected request
// -----------------------------------------------------------------------------
module parking_controller_n #(
    parameter int SLOTS     = 8,
    parameter int IDX_W     = $clog2(SLOTS),
    parameter int CNT_W     = $clog2(SLOTS + 1),
    parameter int DOOR_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             entry_sensor,
    input  logic             exit_sensor,
    input  logic [IDX_W-1:0] exit_slot,
    input  logic             lock_en,
    output logic [SLOTS-1:0] parking_slots,
    output logic [CNT_W-1:0] capacity,
    output logic [IDX_W-1:0] best_place,
    output logic             full_light,
    output logic             door_open_light,
    output logic             reject_light
);

    localparam int               TMR_W     = $clog2(DOOR_HOLD + 1);
    localparam logic [TMR_W-1:0] HOLD_LD   = TMR_W'(DOOR_HOLD);
    localparam logic [CNT_W-1:0] SLOTS_CNT = CNT_W'(SLOTS);

    typedef enum logic [0:0] {
        DOOR_CLOSED = 1'b0,
        DOOR_OPEN   = 1'b1
    } door_state_e;

    // Number of free slots in an occupancy vector.
    function automatic logic [CNT_W-1:0] count_free(input logic [SLOTS-1:0] occ);
        logic [CNT_W-1:0] n;
        n = SLOTS_CNT;
        for (int i = 0; i < SLOTS; i++) begin
            n = n - CNT_W'(occ[i]);
        end
        return n;
    endfunction

    // Lowest-index free slot; 0 when there is no free slot.
    function automatic logic [IDX_W-1:0] lowest_free(input logic [SLOTS-1:0] occ);
        logic [IDX_W-1:0] idx;
        logic             found;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!occ[i] && !found) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return idx;
    endfunction

    // Registered state
    logic              entry_prev_q, exit_prev_q;
    logic [SLOTS-1:0]  slots_q, slots_d;
    logic [CNT_W-1:0]  capacity_q, capacity_d;
    logic [IDX_W-1:0]  best_q, best_d;
    logic              full_q, full_d;
    logic              reject_q, reject_d;
    logic              door_light_q, door_light_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    door_state_e       door_state_q, door_state_d;

    // Combinational helpers
    logic              entry_ev_s, exit_ev_s;
    logic              entry_ok_s, exit_ok_s;
    logic [SLOTS-1:0]  entry_mask_s, exit_hit_s;

    // Event detection, acceptance and the next slot vector with derived status.
    always_comb begin
        entry_ev_s   = entry_sensor & ~entry_prev_q;
        exit_ev_s    = exit_sensor & ~exit_prev_q;
        entry_mask_s = '0;
        exit_hit_s   = '0;
        // Decoding exit_slot against each slot index makes an out-of-range
        // exit_slot hit nothing, so it is rejected like an empty slot.
        for (int i = 0; i < SLOTS; i++) begin
            entry_mask_s[i] = (best_q == IDX_W'(i));
            exit_hit_s[i]   = (exit_slot == IDX_W'(i));
        end
        // Both events are judged against the pre-edge state.
        entry_ok_s = entry_ev_s & ~full_q & ~lock_en;
        exit_ok_s  = exit_ev_s & (|(slots_q & exit_hit_s));

        slots_d = slots_q;
        if (entry_ok_s) begin
            slots_d = slots_d | entry_mask_s;
        end else begin
            slots_d = slots_d;
        end
        if (exit_ok_s) begin
            slots_d = slots_d & ~exit_hit_s;
        end else begin
            slots_d = slots_d;
        end

        reject_d   = (entry_ev_s & ~entry_ok_s) | (exit_ev_s & ~exit_ok_s);
        capacity_d = count_free(slots_d);
        best_d     = lowest_free(slots_d);
        full_d     = (capacity_d == '0);
    end

    // Door FSM next state: any accepted event (re)loads the hold timer.
    always_comb begin
        door_state_d = door_state_q;
        timer_d      = timer_q;
        case (door_state_q)
            DOOR_CLOSED: begin
                if (entry_ok_s || exit_ok_s) begin
                    door_state_d = DOOR_OPEN;
                    timer_d      = HOLD_LD;
                end else begin
                    timer_d      = '0;
                end
            end
            DOOR_OPEN: begin
                if (entry_ok_s || exit_ok_s) begin
                    timer_d = HOLD_LD;
                end else if (timer_q <= TMR_W'(1)) begin
                    timer_d      = '0;
                    door_state_d = DOOR_CLOSED;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: begin
                door_state_d = DOOR_CLOSED;
                timer_d      = '0;
            end
        endcase
        // Light follows the timer value that this edge loads.
        door_light_d = (timer_d != '0);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            // History loads the live levels so a sensor held through reset is no event.
            entry_prev_q <= entry_sensor;
            exit_prev_q  <= exit_sensor;
            slots_q      <= '0;
            capacity_q   <= SLOTS_CNT;
            best_q       <= '0;
            full_q       <= 1'b0;
            reject_q     <= 1'b0;
            door_light_q <= 1'b0;
            timer_q      <= '0;
            door_state_q <= DOOR_CLOSED;
        end else begin
            entry_prev_q <= entry_sensor;
            exit_prev_q  <= exit_sensor;
            slots_q      <= slots_d;
            capacity_q   <= capacity_d;
            best_q       <= best_d;
            full_q       <= full_d;
            reject_q     <= reject_d;
            door_light_q <= door_light_d;
            timer_q      <= timer_d;
            door_state_q <= door_state_d;
        end
    end

    assign parking_slots   = slots_q;
    assign capacity        = capacity_q;
    assign best_place      = best_q;
    assign full_light      = full_q;
    assign door_open_light = door_light_q;
    assign reject_light    = reject_q;

endmodule

// File: tb/tb_parking_controller_n.sv
module tb_parking_controller_n;

    logic       clk = 1'b0;
    logic       rst, entry_sensor, exit_sensor, lock_en;
    logic [1:0] exit_slot;
    logic [3:0] parking_slots;
    logic [2:0] capacity;
    logic [1:0] best_place;
    logic       full_light, door_open_light, reject_light;

    logic       rst8, entry8, exit8;
    logic [2:0] exit_slot8;
    logic [7:0] slots8;
    logic [3:0] cap8;
    logic [2:0] best8;
    logic       full8, door8, rej8;

    int total = 0;
    int bad   = 0;

    // Reference model state (SLOTS=4, DOOR_HOLD=3)
    bit m_occ[4];
    int m_door;
    bit m_rej;
    bit m_pe, m_px;

    always #5 clk = ~clk;

    parking_controller_n #(.SLOTS(4), .DOOR_HOLD(3)) u_dut (
        .clk(clk), .rst(rst), .entry_sensor(entry_sensor), .exit_sensor(exit_sensor),
        .exit_slot(exit_slot), .lock_en(lock_en), .parking_slots(parking_slots),
        .capacity(capacity), .best_place(best_place), .full_light(full_light),
        .door_open_light(door_open_light), .reject_light(reject_light)
    );

    parking_controller_n #(.SLOTS(8), .DOOR_HOLD(3)) u_dut8 (
        .clk(clk), .rst(rst8), .entry_sensor(entry8), .exit_sensor(exit8),
        .exit_slot(exit_slot8), .lock_en(1'b0), .parking_slots(slots8),
        .capacity(cap8), .best_place(best8), .full_light(full8),
        .door_open_light(door8), .reject_light(rej8)
    );

    // Advance the model by one clock edge using the input levels present at that edge.
    task automatic model_edge();
        bit ev_en, ev_ex, ok_en, ok_ex;
        int free_n, low;
        if (rst) begin
            foreach (m_occ[i]) m_occ[i] = 1'b0;
            m_door = 0;
            m_rej  = 1'b0;
        end else begin
            ev_en  = entry_sensor && !m_pe;
            ev_ex  = exit_sensor && !m_px;
            free_n = 0;
            low    = -1;
            for (int i = 0; i < 4; i++) begin
                if (!m_occ[i]) begin
                    free_n++;
                    if (low < 0) low = i;
                end
            end
            ok_en = ev_en && (free_n > 0) && !lock_en;
            ok_ex = ev_ex && m_occ[exit_slot];
            m_rej = (ev_en && !ok_en) || (ev_ex && !ok_ex);
            if (ok_en) m_occ[low] = 1'b1;
            if (ok_ex) m_occ[exit_slot] = 1'b0;
            if (ok_en || ok_ex) m_door = 3;
            else if (m_door > 0) m_door--;
        end
        m_pe = entry_sensor;
        m_px = exit_sensor;
    endtask

    function automatic logic [3:0] m_vec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_occ[i];
        return v;
    endfunction

    function automatic int m_free();
        int n = 0;
        for (int i = 0; i < 4; i++) if (!m_occ[i]) n++;
        return n;
    endfunction

    function automatic int m_low();
        for (int i = 0; i < 4; i++) if (!m_occ[i]) return i;
        return 0;
    endfunction

    // One clock: inputs already driven; model steps at the edge; sample on negedge.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_entry();
        entry_sensor = 1'b1; cyc();
        entry_sensor = 1'b0; cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc();
        rst = 1'b0; cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1; cyc(); cyc();
        total++; if (parking_slots !== 4'b0000) begin bad++; $display("FAIL reset_slots got=%b exp=0000", parking_slots); end
        total++; if (capacity !== 3'd4) begin bad++; $display("FAIL reset_cap got=%0d exp=4", capacity); end
        total++; if (best_place !== 2'd0) begin bad++; $display("FAIL reset_best got=%0d exp=0", best_place); end
        total++; if ({full_light, door_open_light, reject_light} !== 3'b000) begin bad++; $display("FAIL reset_lights got=%b exp=000", {full_light, door_open_light, reject_light}); end
        rst = 1'b0; cyc();
    endtask

    task automatic test_fill();
        logic [4:0] exp_v;
        for (int k = 0; k < 5; k++) begin
            entry_sensor = 1'b1; cyc();
            if (k < 4) begin
                exp_v = (5'd1 << (k + 1)) - 5'd1;
                total++; if (parking_slots !== exp_v[3:0]) begin bad++; $display("FAIL fill_slots k=%0d got=%b exp=%b", k, parking_slots, exp_v[3:0]); end
                total++; if (capacity !== 3'(3 - k)) begin bad++; $display("FAIL fill_cap k=%0d got=%0d exp=%0d", k, capacity, 3 - k); end
                total++; if (full_light !== (k == 3)) begin bad++; $display("FAIL fill_full k=%0d got=%b exp=%b", k, full_light, k == 3); end
                total++; if ({door_open_light, reject_light} !== 2'b10) begin bad++; $display("FAIL fill_door_rej k=%0d got=%b exp=10", k, {door_open_light, reject_light}); end
            end else begin
                total++; if ({reject_light, door_open_light} !== 2'b10) begin bad++; $display("FAIL full_reject got rej,door=%b exp=10", {reject_light, door_open_light}); end
                total++; if (parking_slots !== 4'b1111) begin bad++; $display("FAIL full_slots got=%b exp=1111", parking_slots); end
            end
            entry_sensor = 1'b0; cyc();
            if (k == 4) begin
                total++; if (reject_light !== 1'b0) begin bad++; $display("FAIL reject_pulse_width got=%b exp=0", reject_light); end
            end
            repeat (3) cyc();
        end
    endtask

    task automatic test_exit();
        exit_slot = 2'd1; exit_sensor = 1'b1; cyc();
        total++; if (parking_slots !== 4'b1101) begin bad++; $display("FAIL exit_slots got=%b exp=1101", parking_slots); end
        total++; if (capacity !== 3'd1 || best_place !== 2'd1) begin bad++; $display("FAIL exit_cap_best got=%0d/%0d exp=1/1", capacity, best_place); end
        total++; if (full_light !== 1'b0 || reject_light !== 1'b0) begin bad++; $display("FAIL exit_full_rej got=%b%b exp=00", full_light, reject_light); end
        exit_sensor = 1'b0; repeat (4) cyc();
        exit_sensor = 1'b1; cyc();
        total++; if (reject_light !== 1'b1 || parking_slots !== 4'b1101) begin bad++; $display("FAIL exit_empty_rej got rej=%b slots=%b exp=1 1101", reject_light, parking_slots); end
        exit_sensor = 1'b0; repeat (4) cyc();
    endtask

    task automatic test_simultaneous();
        do_reset();
        repeat (3) do_entry();
        entry_sensor = 1'b1; exit_sensor = 1'b1; exit_slot = 2'd0; cyc();
        total++; if (parking_slots !== 4'b1110) begin bad++; $display("FAIL simul_slots got=%b exp=1110", parking_slots); end
        total++; if (capacity !== 3'd1 || best_place !== 2'd0 || reject_light !== 1'b0) begin bad++; $display("FAIL simul_status got cap=%0d best=%0d rej=%b exp=1 0 0", capacity, best_place, reject_light); end
        entry_sensor = 1'b0; exit_sensor = 1'b0; cyc();
        do_entry();
        entry_sensor = 1'b1; exit_sensor = 1'b1; exit_slot = 2'd2; cyc();
        total++; if (parking_slots !== 4'b1011 || reject_light !== 1'b1) begin bad++; $display("FAIL simul_full got slots=%b rej=%b exp=1011 1", parking_slots, reject_light); end
        total++; if (capacity !== 3'd1 || best_place !== 2'd2 || full_light !== 1'b0) begin bad++; $display("FAIL simul_full_status got cap=%0d best=%0d full=%b exp=1 2 0", capacity, best_place, full_light); end
        entry_sensor = 1'b0; exit_sensor = 1'b0; cyc();
    endtask

    task automatic test_door();
        int high, rejcnt;
        do_reset();
        entry_sensor = 1'b1; cyc();
        high = door_open_light ? 1 : 0;
        entry_sensor = 1'b0;
        repeat (4) begin cyc(); if (door_open_light) high++; end
        total++; if (high !== 3) begin bad++; $display("FAIL door_hold got=%0d exp=3", high); end
        entry_sensor = 1'b1; cyc();
        entry_sensor = 1'b0; cyc();
        entry_sensor = 1'b1; cyc();
        entry_sensor = 1'b0;
        total++; if (door_open_light !== 1'b1) begin bad++; $display("FAIL door_reload got=%b exp=1", door_open_light); end
        cyc(); cyc();
        total++; if (door_open_light !== 1'b1) begin bad++; $display("FAIL door_reload_hold got=%b exp=1", door_open_light); end
        cyc();
        total++; if (door_open_light !== 1'b0) begin bad++; $display("FAIL door_reload_close got=%b exp=0", door_open_light); end
        rejcnt = 0;
        entry_sensor = 1'b1;
        repeat (10) begin cyc(); if (reject_light) rejcnt++; end
        entry_sensor = 1'b0; cyc();
        total++; if (parking_slots !== 4'b1111 || rejcnt !== 0) begin bad++; $display("FAIL held_level got slots=%b rej=%0d exp=1111 0", parking_slots, rejcnt); end
    endtask

    task automatic test_lock_and_reset();
        do_reset();
        do_entry();
        lock_en = 1'b1; entry_sensor = 1'b1; cyc();
        total++; if (reject_light !== 1'b1 || parking_slots !== 4'b0001) begin bad++; $display("FAIL lock_entry got rej=%b slots=%b exp=1 0001", reject_light, parking_slots); end
        entry_sensor = 1'b0; cyc();
        exit_sensor = 1'b1; exit_slot = 2'd0; cyc();
        total++; if (parking_slots !== 4'b0000 || reject_light !== 1'b0 || door_open_light !== 1'b1) begin bad++; $display("FAIL lock_exit got slots=%b rej=%b door=%b exp=0000 0 1", parking_slots, reject_light, door_open_light); end
        exit_sensor = 1'b0; lock_en = 1'b0; cyc();
        entry_sensor = 1'b1; cyc();
        rst = 1'b1; cyc();
        total++; if (parking_slots !== 4'b0000 || capacity !== 3'd4 || door_open_light !== 1'b0) begin bad++; $display("FAIL mid_reset got slots=%b cap=%0d door=%b exp=0000 4 0", parking_slots, capacity, door_open_light); end
        rst = 1'b0; repeat (3) cyc();
        total++; if (parking_slots !== 4'b0000 || door_open_light !== 1'b0 || reject_light !== 1'b0) begin bad++; $display("FAIL post_reset_held got slots=%b door=%b rej=%b exp=0000 0 0", parking_slots, door_open_light, reject_light); end
        entry_sensor = 1'b0; cyc();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            entry_sensor = ($urandom % 3) == 0;
            exit_sensor  = ($urandom % 3) == 0;
            exit_slot    = 2'($urandom % 4);
            lock_en      = ($urandom % 8) == 0;
            rst          = ($urandom % 80) == 0;
            cyc();
            total++;
            if (parking_slots !== m_vec() || capacity !== 3'(m_free()) || best_place !== 2'(m_low())
                || full_light !== (m_free() == 0) || door_open_light !== (m_door > 0) || reject_light !== m_rej) begin
                bad++;
                $display("FAIL random n=%0d got slots=%b cap=%0d best=%0d full=%b door=%b rej=%b exp %b %0d %0d %b %b %b",
                         n, parking_slots, capacity, best_place, full_light, door_open_light, reject_light,
                         m_vec(), m_free(), m_low(), m_free() == 0, m_door > 0, m_rej);
            end
        end
        rst = 1'b0; entry_sensor = 1'b0; exit_sensor = 1'b0; lock_en = 1'b0; cyc();
    endtask

    task automatic test_eight_slots();
        logic [8:0] exp_v;
        rst8 = 1'b1; cyc(); cyc();
        rst8 = 1'b0; cyc();
        total++; if (slots8 !== 8'h00 || cap8 !== 4'd8 || best8 !== 3'd0 || full8 !== 1'b0) begin bad++; $display("FAIL s8_reset got slots=%b cap=%0d best=%0d full=%b", slots8, cap8, best8, full8); end
        for (int k = 0; k < 9; k++) begin
            entry8 = 1'b1; cyc();
            if (k < 8) begin
                exp_v = (9'd1 << (k + 1)) - 9'd1;
                total++; if (slots8 !== exp_v[7:0] || cap8 !== 4'(7 - k) || full8 !== (k == 7) || rej8 !== 1'b0) begin bad++; $display("FAIL s8_fill k=%0d got slots=%b cap=%0d full=%b rej=%b", k, slots8, cap8, full8, rej8); end
            end else begin
                total++; if (rej8 !== 1'b1 || slots8 !== 8'hFF || door8 !== 1'b0) begin bad++; $display("FAIL s8_full_reject got rej=%b slots=%b door=%b exp=1 11111111 0", rej8, slots8, door8); end
            end
            entry8 = 1'b0; repeat (4) cyc();
        end
        exit_slot8 = 3'd1; exit8 = 1'b1; cyc();
        total++; if (slots8 !== 8'b1111_1101 || cap8 !== 4'd1 || best8 !== 3'd1 || full8 !== 1'b0) begin bad++; $display("FAIL s8_exit got slots=%b cap=%0d best=%0d full=%b exp=11111101 1 1 0", slots8, cap8, best8, full8); end
        exit8 = 1'b0; repeat (4) cyc();
        exit8 = 1'b1; cyc();
        total++; if (rej8 !== 1'b1 || slots8 !== 8'b1111_1101) begin bad++; $display("FAIL s8_exit_rej got rej=%b slots=%b exp=1 11111101", rej8, slots8); end
        exit8 = 1'b0; cyc();
    endtask

    initial begin
        rst = 1'b1; entry_sensor = 1'b0; exit_sensor = 1'b0; exit_slot = 2'd0; lock_en = 1'b0;
        rst8 = 1'b1; entry8 = 1'b0; exit8 = 1'b0; exit_slot8 = 3'd0;
        m_pe = 1'b0; m_px = 1'b0; m_door = 0; m_rej = 1'b0;
        foreach (m_occ[i]) m_occ[i] = 1'b0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_exit();
        test_simultaneous();
        test_door();
        test_lock_and_reset();
        test_random();
        test_eight_slots();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
